// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter and the planned IMEM/DMEM bus.
// Contents: FSM state encoding (IDLE, ISSUE) and requester owner IDs (M0, M1).
package dmem_pkg;

    typedef enum logic {
        IDLE  = 1'b0,  // memory port unused this cycle
        ISSUE = 1'b1   // owner's access is on the memory port this cycle
    } dmem_state_e;

    typedef enum logic {
        M0 = 1'b0,  // core LSU
        M1 = 1'b1   // DMA / debug requester
    } dmem_owner_e;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin pick.
// Ports:
//   req0, req1 : eligible requests
//   ptr        : tie-break, 0 favours requester 0, 1 favours requester 1
//   gnt0, gnt1 : one-hot pick (both 0 when nothing is eligible)
module rr_arb2 (
    input  logic req0,
    input  logic req1,
    input  logic ptr,
    output logic gnt0,
    output logic gnt1
);

    always_comb begin
        gnt0 = req0 && (!req1 || !ptr);
        gnt1 = req1 && (!req0 ||  ptr);
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master arbiter in front of a single-port data memory.
// m0 (core LSU) and m1 (DMA/debug) each issue single-cycle accesses; the pick is
// registered, so a request seen in cycle N reaches the memory port in cycle N+1.
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   m0_req/we/addr/wdata/lock     : core request (lock excludes m1 while held)
//   m0_gnt/rvalid/rdata           : core grant pulse, read-data pulse and data
//   m1_req/we/addr/wdata          : DMA/debug request
//   m1_gnt/rvalid/rdata           : DMA/debug grant pulse, read-data pulse and data
//   mem_addr/dataW/MemRW          : memory port drive (all zero when idle)
//   mem_dataR                     : memory read data, combinational from mem_addr
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic              m0_lock,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_dataW,
    output logic              mem_MemRW,
    input  logic [DATA_W-1:0] mem_dataR
);

    dmem_state_e state_q;
    dmem_owner_e owner_q;
    dmem_owner_e rr_ptr_q;  // requester favoured on the next tie
    logic        lock_q;

    logic m0_busy;
    logic m1_busy;
    logic lock_d;
    logic elig0;
    logic elig1;
    logic pick0;
    logic pick1;

    always_comb begin
        m0_busy = (state_q == ISSUE) && (owner_q == M0);
        m1_busy = (state_q == ISSUE) && (owner_q == M1);
        // The lock takes effect in m0's own issue cycle so m1 cannot slip in
        // right behind the locked access; it drops as soon as m0_lock falls.
        lock_d  = m0_lock && (lock_q || m0_busy);
        // The current owner is excluded so one request is never issued twice.
        elig0   = m0_req && !m0_busy;
        elig1   = m1_req && !m1_busy && !lock_d;
    end

    rr_arb2 u_rr_arb2 (
        .req0 (elig0),
        .req1 (elig1),
        .ptr  (rr_ptr_q == M1),
        .gnt0 (pick0),
        .gnt1 (pick1)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            owner_q   <= M0;
            rr_ptr_q  <= M0;
            lock_q    <= 1'b0;
            m0_gnt    <= 1'b0;
            m1_gnt    <= 1'b0;
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
            mem_addr  <= '0;
            mem_dataW <= '0;
            mem_MemRW <= 1'b0;
        end else begin
            lock_q <= lock_d;

            // Read results are captured at the end of the issue cycle.
            m0_rvalid <= m0_busy && !mem_MemRW;
            m1_rvalid <= m1_busy && !mem_MemRW;
            if (m0_busy && !mem_MemRW) begin
                m0_rdata <= mem_dataR;
            end
            if (m1_busy && !mem_MemRW) begin
                m1_rdata <= mem_dataR;
            end

            if (pick0 || pick1) begin
                state_q  <= ISSUE;
                owner_q  <= pick1 ? M1 : M0;
                rr_ptr_q <= pick1 ? M0 : M1;
                m0_gnt   <= pick0;
                m1_gnt   <= pick1;
                if (pick1) begin
                    mem_addr  <= m1_addr;
                    mem_dataW <= m1_wdata;
                    mem_MemRW <= m1_we;
                end else begin
                    mem_addr  <= m0_addr;
                    mem_dataW <= m0_wdata;
                    mem_MemRW <= m0_we;
                end
            end else begin
                state_q   <= IDLE;
                m0_gnt    <= 1'b0;
                m1_gnt    <= 1'b0;
                mem_addr  <= '0;
                mem_dataW <= '0;
                mem_MemRW <= 1'b0;
            end
        end
    end

endmodule
